// File: rtl/mem_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and a single-port data memory.
//   m0_*/m1_* : per-requester request (req/we/addr/wdata) and response
//               (gnt/rvalid/err/rdata) signals
//   mem_*     : memory-side address, write data, write enable and read data
// modport slave  : the arbiter's view
// modport master : the environment's view (requesters plus memory)
interface mem_arbiter_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_gnt;
  logic          m0_rvalid;
  logic          m0_err;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_gnt;
  logic          m1_rvalid;
  logic          m1_err;
  logic [DW-1:0] m1_rdata;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_err, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_err, m1_rdata,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_err, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_err, m1_rdata,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// One transaction at a time: IDLE (grant) -> WAIT x WAIT_CYCLES -> ACCESS -> RESP.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mem_arbiter_if.slave (requester ports m0_*/m1_*, memory ports mem_*)
// Misaligned addresses (addr[1:0] != 0) never write memory and respond with err.
module mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  state_t        state;
  logic          ptr;
  logic [CW-1:0] cnt;
  logic          lat_id;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;

  logic          any_req;
  logic          pick;
  logic          idle;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          aligned;

  // Arbitration: round-robin pointer only matters when both requesters are active.
  assign any_req   = bus.m0_req | bus.m1_req;
  assign pick      = (bus.m0_req & bus.m1_req) ? ptr : bus.m1_req;
  assign idle      = rst_n && (state == IDLE);
  assign sel_we    = pick ? bus.m1_we    : bus.m0_we;
  assign sel_addr  = pick ? bus.m1_addr  : bus.m0_addr;
  assign sel_wdata = pick ? bus.m1_wdata : bus.m0_wdata;
  assign aligned   = (lat_addr[1:0] == 2'b00);

  // Grant is combinational in IDLE so the requester sees it in its request cycle.
  assign bus.m0_gnt = idle & any_req & ~pick;
  assign bus.m1_gnt = idle & any_req &  pick;

  assign bus.mem_addr  = lat_addr;
  assign bus.mem_wdata = lat_wdata;

  // Transaction sequencer with registered memory strobe and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= 1'b0;
      cnt           <= '0;
      lat_id        <= 1'b0;
      lat_we        <= 1'b0;
      lat_addr      <= '0;
      lat_wdata     <= '0;
      bus.mem_we    <= 1'b0;
      bus.m0_rvalid <= 1'b0;
      bus.m0_err    <= 1'b0;
      bus.m0_rdata  <= '0;
      bus.m1_rvalid <= 1'b0;
      bus.m1_err    <= 1'b0;
      bus.m1_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            lat_id    <= pick;
            lat_we    <= sel_we;
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wdata;
            ptr       <= ~pick;
            if (WAIT_CYCLES != 0) begin
              state <= WAIT;
              cnt   <= CW'(WAIT_CYCLES - 1);
            end else begin
              state      <= ACCESS;
              bus.mem_we <= sel_we & (sel_addr[1:0] == 2'b00);
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state      <= ACCESS;
            bus.mem_we <= lat_we & aligned;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ACCESS: begin
          // Response fields become visible in RESP; rdata only moves on aligned reads.
          bus.mem_we <= 1'b0;
          state      <= RESP;
          if (lat_id) begin
            bus.m1_rvalid <= 1'b1;
            bus.m1_err    <= ~aligned;
            if (!lat_we && aligned) bus.m1_rdata <= bus.mem_rdata;
          end else begin
            bus.m0_rvalid <= 1'b1;
            bus.m0_err    <= ~aligned;
            if (!lat_we && aligned) bus.m0_rdata <= bus.mem_rdata;
          end
        end
        RESP: begin
          bus.m0_rvalid <= 1'b0;
          bus.m1_rvalid <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter (WAIT_CYCLES=2): the sequencer pushes expected
// grants, memory writes and responses; a negedge monitor pops and compares them.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_init_n = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter #(.WAIT_CYCLES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Word memory model: preloaded with 0xA500_0000 | word index.
  logic [31:0] mem [0:63];
  always @(posedge clk) begin
    if (!mem_init_n) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA500_0000 | 32'(i);
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end
  end
  assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

  typedef struct packed { logic m; logic err; logic [31:0] rdata; } rsp_t;
  typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;

  bit   gq[$];
  wr_t  wq[$];
  rsp_t rq[$];

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int gnt_cyc = 0;
  logic [31:0] exp_rd [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: compares every grant, memory write and response against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.m0_gnt && bus.m1_gnt) chk("dual gnt", 32'd1, 32'd0);
      if (bus.m0_gnt || bus.m1_gnt) begin
        gnt_cyc = cyc;
        if (gq.size() == 0) chk("unexpected gnt", 32'd1, 32'd0);
        else chk("gnt master", 32'(bus.m1_gnt), 32'(gq.pop_front()));
      end
      if (bus.mem_we) begin
        if (wq.size() == 0) chk("unexpected mem_we", 32'd1, 32'd0);
        else begin
          wr_t w;
          w = wq.pop_front();
          chk("mem_addr", bus.mem_addr, w.addr);
          chk("mem_wdata", bus.mem_wdata, w.data);
          chk("mem_we latency", 32'(cyc - gnt_cyc), 32'd3);
        end
      end
      if (bus.m0_rvalid && bus.m1_rvalid) chk("dual rvalid", 32'd1, 32'd0);
      if (bus.m0_rvalid || bus.m1_rvalid) begin
        if (rq.size() == 0) chk("unexpected rvalid", 32'd1, 32'd0);
        else begin
          rsp_t r;
          r = rq.pop_front();
          chk("rvalid master", 32'(bus.m1_rvalid), 32'(r.m));
          chk("err", 32'(r.m ? bus.m1_err : bus.m0_err), 32'(r.err));
          chk("rdata", r.m ? bus.m1_rdata : bus.m0_rdata, r.rdata);
          chk("rvalid latency", 32'(cyc - gnt_cyc), 32'd4);
        end
      end
    end
  end

  task automatic set_req(input bit m, input bit v, input bit we,
                         input logic [31:0] addr, input logic [31:0] wdata);
    if (m) begin
      bus.m1_req = v; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata;
    end else begin
      bus.m0_req = v; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata;
    end
  endtask

  task automatic wait_gnt(input bit m, output bit ok);
    int n;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 40) begin
      @(negedge clk);
      ok = m ? bus.m1_gnt : bus.m0_gnt;
      n++;
    end
    if (!ok) chk("gnt timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (rq.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (rq.size() != 0) chk("response timeout", 32'(rq.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Queue the expected outcome of one transaction; rd is the memory word for reads.
  task automatic expect_txn(input bit m, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rd);
    logic [1:0] lo;
    rsp_t r;
    lo = addr[1:0];
    gq.push_back(m);
    if (we && lo == 2'b00) wq.push_back('{addr: addr, data: wdata});
    if (!we && lo == 2'b00) exp_rd[m] = rd;
    r.m = m;
    r.err = (lo != 2'b00);
    r.rdata = exp_rd[m];
    rq.push_back(r);
  endtask

  task automatic txn(input bit m, input bit we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] rd);
    bit ok;
    expect_txn(m, we, addr, wdata, rd);
    set_req(m, 1'b1, we, addr, wdata);
    wait_gnt(m, ok);
    @(posedge clk);
    #1;
    set_req(m, 1'b0, 1'b0, 32'h0, 32'h0);
    wait_idle();
  endtask

  task automatic check_reset_outputs();
    chk("reset flags", {25'b0, bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid,
                        bus.m0_err, bus.m1_err, bus.mem_we}, 32'd0);
    chk("reset m0_rdata", bus.m0_rdata, 32'd0);
    chk("reset m1_rdata", bus.m1_rdata, 32'd0);
    chk("reset mem_addr", bus.mem_addr, 32'd0);
    chk("reset mem_wdata", bus.mem_wdata, 32'd0);
    exp_rd[0] = 32'd0;
    exp_rd[1] = 32'd0;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n;
    int gc [4];
    int c0;
    int c1;
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    exp_rd[0] = 32'd0;
    exp_rd[1] = 32'd0;

    // Power-on reset and memory preload.
    repeat (2) @(posedge clk);
    #1;
    mem_init_n = 1'b1;
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // m0 write then read-back through wait states.
    txn(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0);
    txn(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF);

    // Both requesting continuously from reset: strict alternation starting at m0.
    pulse_reset();
    for (int k = 0; k < 2; k++) begin
      expect_txn(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF);
      expect_txn(1'b1, 1'b0, 32'h20, 32'h0, 32'hA500_0008);
    end
    set_req(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    set_req(1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
    n = 0;
    for (int i = 0; i < 100 && n < 4; i++) begin
      @(negedge clk);
      if (bus.m0_gnt || bus.m1_gnt) n++;
    end
    chk("rr grant count", 32'(n), 32'd4);
    @(posedge clk);
    #1;
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    wait_idle();

    // m1 alone, four back-to-back reads: one grant every 5 cycles.
    for (int k = 0; k < 4; k++) expect_txn(1'b1, 1'b0, 32'h20, 32'h0, 32'hA500_0008);
    set_req(1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
    for (int k = 0; k < 4; k++) begin
      wait_gnt(1'b1, ok);
      gc[k] = cyc;
    end
    @(posedge clk);
    #1;
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    wait_idle();
    for (int k = 1; k < 4; k++) chk("b2b grant spacing", 32'(gc[k] - gc[k-1]), 32'd5);

    // Misaligned m1 write: no memory write, err set, rdata held.
    txn(1'b1, 1'b1, 32'h13, 32'h5555_AAAA, 32'h0);
    chk("misaligned no write", mem[4], 32'hDEAD_BEEF);

    // Reset during the ACCESS cycle of an m0 write discards it.
    gq.push_back(1'b0);
    set_req(1'b0, 1'b1, 1'b1, 32'h30, 32'h1234_5678);
    wait_gnt(1'b0, ok);
    @(posedge clk);
    #1;
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("aborted write discarded", mem[12], 32'hA500_000C);
    txn(1'b0, 1'b0, 32'h30, 32'h0, 32'hA500_000C);

    // m0 request raised during m1 WAIT is granted in the IDLE cycle after m1 RESP.
    expect_txn(1'b1, 1'b0, 32'h20, 32'h0, 32'hA500_0008);
    expect_txn(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF);
    set_req(1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
    wait_gnt(1'b1, ok);
    c1 = cyc;
    @(posedge clk);
    #1;
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    wait_gnt(1'b0, ok);
    c0 = cyc;
    chk("deferred m0 gnt", 32'(c0 - c1), 32'd5);
    @(posedge clk);
    #1;
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    wait_idle();

    repeat (4) @(posedge clk);
    chk("leftover grants", 32'(gq.size()), 32'd0);
    chk("leftover writes", 32'(wq.size()), 32'd0);
    chk("leftover responses", 32'(rq.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 1, number of wait-state cycles inserted before each memory access (legal 0..15).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 m0_req  input  1  requester 0 access request, held until m0_gnt.
REQ-005 m0_we  input  1  requester 0 write enable (1 write, 0 read).
REQ-006 m0_addr  input  32  requester 0 byte address, word-aligned.
REQ-007 m0_wdata  input  32  requester 0 write data.
REQ-008 m0_gnt  output  1  requester 0 request accepted this cycle.
REQ-009 m0_rvalid  output  1  requester 0 completion pulse.
REQ-010 m0_err  output  1  requester 0 misaligned-address error, valid with m0_rvalid.
REQ-011 m0_rdata  output  32  requester 0 read data, valid with m0_rvalid.
REQ-012 m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_err, m1_rdata: requester 1 ports, same directions, widths and meanings as requester 0.
REQ-013 mem_addr  output  32  byte address to the single-port data memory (memory indexes words by addr>>2).
REQ-014 mem_wdata  output  32  write data to memory.
REQ-015 mem_we  output  1  memory write enable, sampled by memory on rising clk.
REQ-016 mem_rdata  input  32  combinational memory read data for mem_addr.

Function
REQ-017 FSM states SHALL be IDLE, WAIT, ACCESS, RESP.
REQ-018 IDLE: if any req high, SHALL assert the chosen master's gnt combinationally that cycle, latch its we/addr/wdata and master id at the edge, go to WAIT (WAIT_CYCLES>0) or ACCESS (WAIT_CYCLES=0); no req -> stay IDLE.
REQ-019 gnt SHALL be asserted only in IDLE, to at most one master, for exactly one cycle per transaction.
REQ-020 Both req high in IDLE: grant the master named by a 1-bit round-robin pointer; pointer SHALL flip to the other master after every grant.
REQ-021 Only one req high: grant it regardless of pointer; pointer still set to the other master.
REQ-022 WAIT: 4-bit counter loaded with WAIT_CYCLES-1 on entry, decrements each cycle; at 0 go to ACCESS.
REQ-023 ACCESS (one cycle): mem_we SHALL equal latched we AND aligned; read data SHALL be captured from mem_rdata at end of cycle when latched we=0 and aligned; go to RESP.
REQ-024 Aligned means latched addr[1:0]==2'b00; misaligned transactions SHALL never assert mem_we.
REQ-025 RESP (one cycle): granted master's rvalid=1; err=1 if misaligned else 0; rdata = captured word for aligned reads, unchanged otherwise; go to IDLE.
REQ-026 Latency: gnt in cycle T -> ACCESS in T+1+WAIT_CYCLES -> rvalid in T+2+WAIT_CYCLES; next grant no earlier than T+3+WAIT_CYCLES.
REQ-027 mem_addr/mem_wdata SHALL always drive the latched registers; mem_we SHALL be 0 outside ACCESS.
REQ-028 Requests arriving outside IDLE SHALL be ignored until IDLE; a req still high the cycle after gnt is a new request.
REQ-029 m*_rdata and m*_err SHALL hold their values between that master's rvalid pulses.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, pointer to requester 0, counter 0, all latches 0, and every output (gnt, rvalid, err, rdata, mem_addr, mem_wdata, mem_we) to 0.
REQ-031 Reset during WAIT/ACCESS/RESP SHALL discard the transaction: no mem_we, no rvalid after release.
REQ-032 First rising clk after rst_n release SHALL be normal IDLE operation.

Verification
REQ-033 WAIT_CYCLES=2, m0 write 0x10/0xDEADBEEF at T -> m0_gnt at T, mem_we=1 only in T+3, m0_rvalid at T+4 with m0_err=0; then m0 read 0x10 -> m0_rdata=0xDEADBEEF.
REQ-034 After reset, m0_req and m1_req held high continuously -> grant order m0,m1,m0,m1; each rvalid goes to the matching master only.
REQ-035 m1 alone, four back-to-back reads -> four m1_gnt pulses every 3+WAIT_CYCLES cycles, none for m0.
REQ-036 m1 write to 0x13 -> no mem_we pulse, m1_rvalid with m1_err=1, m1_rdata unchanged.
REQ-037 rst_n low in ACCESS cycle of m0 write -> mem_we=0, all outputs 0, no m0_rvalid; m0 next granted cleanly after release.
REQ-038 m0_req raised during m1 WAIT -> m0_gnt only in the IDLE cycle after m1 RESP.
